// File: rtl/instruction_decoder_pkg.sv
// Shared types and default widths for the pipelined instruction decoder.
// The struct below is the default-width view of the decoded payload.
package instruction_decoder_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int OP_W_DEF    = 4;
    localparam int REG_W_DEF   = 3;
    localparam int IMM_W_DEF   = 8;
    localparam int EXT_W_DEF   = 16;
    localparam int CNT_W_DEF   = 16;

    typedef struct packed {
        logic [OP_W_DEF-1:0]  opcode;
        logic [REG_W_DEF-1:0] rd;
        logic                 flag;
        logic [REG_W_DEF-1:0] ra;
        logic [REG_W_DEF-1:0] rb;
        logic [EXT_W_DEF-1:0] imm;
        logic                 illegal;
        logic                 wb_en;
    } dec_fields_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/decode_skid_buf.sv
// Two-entry valid/ready skid buffer with registered in_ready.
// Output register feeds the consumer; skid holds the overflow item.
module decode_skid_buf
    import instruction_decoder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         rdy_q, rdy_d;
    logic         in_xfer;
    logic         out_xfer;

    always_comb begin
        in_xfer  = in_valid && rdy_q && !flush;
        out_xfer = (state_q != EMPTY) && out_ready;
        state_d  = state_q;
        out_d    = out_q;
        skid_d   = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    out_d   = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    out_d = in_data;
                end else if (in_xfer) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        // Registered ready: looks ahead at the next state.
        rdy_d = (state_d != FULL);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_q;

endmodule

// File: rtl/instruction_decoder_pipe.sv
// Field decode, mask classification and illegal counter in front
// of a skid buffer carrying the decoded struct to execute.
module instruction_decoder_pipe
    import instruction_decoder_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int IMM_W   = IMM_W_DEF,
    parameter int EXT_W   = EXT_W_DEF,
    parameter logic [(1<<OP_W)-1:0] ILLEGAL_MASK = '0,
    parameter logic [(1<<OP_W)-1:0] WB_MASK      = '1,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               sign_ext,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    opcode,
    output logic [REG_W-1:0]   rDadrs,
    output logic               flag,
    output logic [REG_W-1:0]   rAadrs,
    output logic [REG_W-1:0]   rBadrs,
    output logic [EXT_W-1:0]   imm,
    output logic               illegal,
    output logic               wb_en,
    output logic [CNT_W-1:0]   illegal_count
);

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [REG_W-1:0] rd;
        logic             flag;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [EXT_W-1:0] imm;
        logic             illegal;
        logic             wb_en;
    } dec_t;

    localparam logic [EXT_W-1:0] HI_MASK =
        ~EXT_W'({IMM_W{1'b1}});

    dec_t             dec;
    dec_t             out_dec;
    logic [IMM_W-1:0] raw;
    logic             accept;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        raw         = instr[IMM_W-1:0];
        dec.opcode  = instr[INSTR_W-1 -: OP_W];
        dec.rd      = instr[INSTR_W-1-OP_W -: REG_W];
        dec.flag    = instr[IMM_W];
        dec.ra      = instr[IMM_W-1 -: REG_W];
        dec.rb      = instr[IMM_W-1-REG_W -: REG_W];
        dec.imm     = EXT_W'(raw);
        if (sign_ext && raw[IMM_W-1]) begin
            dec.imm = dec.imm | HI_MASK;
        end
        dec.illegal = ILLEGAL_MASK[dec.opcode];
        dec.wb_en   = WB_MASK[dec.opcode] && !dec.illegal;
    end

    decode_skid_buf #(
        .W($bits(dec_t))
    ) u_buf (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (dec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_dec)
    );

    // Flushed inputs are discarded, so they are not counted either.
    always_comb begin
        accept = in_valid && in_ready && !flush;
        cnt_d  = cnt_q;
        if (accept && dec.illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign opcode        = out_dec.opcode;
    assign rDadrs        = out_dec.rd;
    assign flag          = out_dec.flag;
    assign rAadrs        = out_dec.ra;
    assign rBadrs        = out_dec.rb;
    assign imm           = out_dec.imm;
    assign illegal       = out_dec.illegal;
    assign wb_en         = out_dec.wb_en;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_instruction_decoder_pipe.sv
// Randomised and directed bench for instruction_decoder_pipe with a
// depth-2 FIFO reference model shared by two differently masked DUTs.
module tb_instruction_decoder_pipe;

    localparam logic [15:0] ILL1 = 16'h8000;
    localparam logic [15:0] WB1  = 16'hFFFF;
    localparam logic [15:0] ILL2 = 16'h8010;
    localparam logic [15:0] WB2  = 16'h0F0F;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        sign_ext = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready1, out_valid1, flag1, ill1, wb1;
    logic [3:0]  op1;
    logic [2:0]  rd1, ra1, rb1;
    logic [15:0] imm1, cnt_o1;
    logic        in_ready2, out_valid2, flag2, ill2, wb2;
    logic [3:0]  op2;
    logic [2:0]  rd2, ra2, rb2;
    logic [15:0] imm2;
    logic [1:0]  cnt_o2;

    logic [31:0] obs1, obs2;
    assign obs1 = {op1, rd1, flag1, ra1, rb1, imm1, ill1, wb1};
    assign obs2 = {op2, rd2, flag2, ra2, rb2, imm2, ill2, wb2};

    int          n_vec = 0;
    int          n_err = 0;
    logic [16:0] mq[$];
    logic        m_ready = 1'b0;
    logic [15:0] cnt1 = '0;
    logic [1:0]  cnt2 = '0;

    always #5 clock = ~clock;

    instruction_decoder_pipe #(
        .ILLEGAL_MASK(ILL1), .WB_MASK(WB1), .CNT_W(16)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .instr(instr), .sign_ext(sign_ext),
        .out_valid(out_valid1), .out_ready(out_ready),
        .opcode(op1), .rDadrs(rd1), .flag(flag1),
        .rAadrs(ra1), .rBadrs(rb1), .imm(imm1),
        .illegal(ill1), .wb_en(wb1), .illegal_count(cnt_o1)
    );

    instruction_decoder_pipe #(
        .ILLEGAL_MASK(ILL2), .WB_MASK(WB2), .CNT_W(2)
    ) dut2 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .instr(instr), .sign_ext(sign_ext),
        .out_valid(out_valid2), .out_ready(out_ready),
        .opcode(op2), .rDadrs(rd2), .flag(flag2),
        .rAadrs(ra2), .rBadrs(rb2), .imm(imm2),
        .illegal(ill2), .wb_en(wb2), .illegal_count(cnt_o2)
    );

    function automatic logic [31:0] model_dec(
        input logic [16:0] e,
        input logic [15:0] im,
        input logic [15:0] wm
    );
        int w, op, rd, fl, ra, rb, iv;
        logic il, wbv;
        w  = int'(e[15:0]);
        op = w / 4096;
        rd = (w / 512) % 8;
        fl = (w / 256) % 2;
        ra = (w / 32) % 8;
        rb = (w / 4) % 8;
        iv = w % 256;
        if (e[16] && iv >= 128) iv = iv + 65280;
        il  = im[op];
        wbv = wm[op] && !il;
        return {op[3:0], rd[2:0], fl[0], ra[2:0], rb[2:0],
                iv[15:0], il, wbv};
    endfunction

    task automatic tick();
        bit acc, pop;
        logic [31:0] d1, d2;
        acc = in_valid && m_ready && !flush;
        pop = out_ready && (mq.size() > 0);
        d1  = model_dec({sign_ext, instr}, ILL1, WB1);
        d2  = model_dec({sign_ext, instr}, ILL2, WB2);
        @(posedge clock);
        if (!reset_n) begin
            mq.delete();
            cnt1 = '0;
            cnt2 = '0;
            m_ready = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_ready = 1'b1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back({sign_ext, instr});
                if (d1[1] && cnt1 != 16'hFFFF) cnt1 = cnt1 + 1;
                if (d2[1] && cnt2 != 2'd3) cnt2 = cnt2 + 1;
            end
            m_ready = (mq.size() < 2);
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({in_ready1, out_valid1, obs1, cnt_o1} !== '0) begin
            n_err++;
            $display("FAIL reset_outs1: got %h/%b/%b/%h want all 0",
                     obs1, in_ready1, out_valid1, cnt_o1);
        end
        n_vec++;
        if ({in_ready2, out_valid2, obs2, cnt_o2} !== '0) begin
            n_err++;
            $display("FAIL reset_outs2: got %h/%b/%b/%h want all 0",
                     obs2, in_ready2, out_valid2, cnt_o2);
        end
        reset_n = 1'b1;
        tick();
        n_vec++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b vld=%b want 1 0",
                     in_ready1, out_valid1);
        end
    endtask

    task automatic test_decode_fields();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 16'hA5F4;
        sign_ext  = 1'b0;
        tick();
        n_vec++;
        if (out_valid1 !== 1'b1 ||
            {op1, rd1, flag1, ra1, rb1} !== {4'hA, 3'd2, 1'b1, 3'd7, 3'd5}) begin
            n_err++;
            $display("FAIL fields: got v=%b %h %h %b %h %h want 1 a 2 1 7 5",
                     out_valid1, op1, rd1, flag1, ra1, rb1);
        end
        n_vec++;
        if (imm1 !== 16'h00F4) begin
            n_err++;
            $display("FAIL imm_zero: got %h want 00f4", imm1);
        end
        sign_ext = 1'b1;
        tick();
        n_vec++;
        if (imm1 !== 16'hFFF4 || out_valid1 !== 1'b1) begin
            n_err++;
            $display("FAIL imm_sign: got %h v=%b want fff4 1",
                     imm1, out_valid1);
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (out_valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL drain: got out_valid=%b want 0", out_valid1);
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] w[3];
        w[0] = 16'h1234;
        w[1] = 16'h5F80;
        w[2] = 16'h2A0C;
        sign_ext  = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = w[i];
            tick();
            n_vec++;
            if (in_ready1 !== (i == 0)) begin
                n_err++;
                $display("FAIL bp_ready%0d: got %b want %b",
                         i, in_ready1, (i == 0));
            end
        end
        n_vec++;
        if (obs1 !== model_dec({1'b1, w[0]}, ILL1, WB1)) begin
            n_err++;
            $display("FAIL bp_hold: got %h want first item", obs1);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            if (i == 3) in_valid = 1'b0;
            tick();
            n_vec++;
            if (i < 3 && (out_valid1 !== 1'b1 ||
                obs1 !== model_dec({1'b1, w[i]}, ILL1, WB1))) begin
                n_err++;
                $display("FAIL bp_order%0d: got v=%b %h want 1 %h", i,
                         out_valid1, obs1,
                         model_dec({1'b1, w[i]}, ILL1, WB1));
            end
            if (i == 3 && out_valid1 !== 1'b0) begin
                n_err++;
                $display("FAIL bp_empty: got out_valid=%b want 0",
                         out_valid1);
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] c0;
        c0 = cnt1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 16'hF123;
        tick();
        n_vec++;
        if (ill1 !== 1'b1 || wb1 !== 1'b0 || cnt_o1 !== c0 + 16'd1) begin
            n_err++;
            $display("FAIL illegal_f: got ill=%b wb=%b cnt=%0d want 1 0 %0d",
                     ill1, wb1, cnt_o1, c0 + 16'd1);
        end
        instr = 16'h3123;
        tick();
        n_vec++;
        if (ill1 !== 1'b0 || wb1 !== 1'b1 || cnt_o1 !== c0 + 16'd1) begin
            n_err++;
            $display("FAIL legal_3: got ill=%b wb=%b cnt=%0d want 0 1 %0d",
                     ill1, wb1, cnt_o1, c0 + 16'd1);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        logic [15:0] c0;
        c0 = cnt1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 16'hF000;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (cnt_o2 !== 2'd3) begin
            n_err++;
            $display("FAIL sat2: got %0d want 3", cnt_o2);
        end
        n_vec++;
        if (cnt_o1 !== c0 + 16'd5) begin
            n_err++;
            $display("FAIL cnt16: got %0d want %0d", cnt_o1, c0 + 16'd5);
        end
    endtask

    task automatic test_flush();
        logic [15:0] c0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 16'h4321;
        tick();
        instr = 16'h6543;
        tick();
        c0 = cnt_o1;
        instr = 16'hF777;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            n_err++;
            $display("FAIL flush_state: got v=%b rdy=%b want 0 1",
                     out_valid1, in_ready1);
        end
        n_vec++;
        if (cnt_o1 !== c0) begin
            n_err++;
            $display("FAIL flush_cnt: got %0d want %0d", cnt_o1, c0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL flush_emit: got out_valid=%b want 0", out_valid1);
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 16'hF111;
        tick();
        tick();
        reset_n = 1'b0;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if ({in_ready1, out_valid1, obs1, cnt_o1, cnt_o2} !== '0) begin
            n_err++;
            $display("FAIL reset_full: got %h/%b/%b/%h want all 0",
                     obs1, in_ready1, out_valid1, cnt_o1);
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        tick();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = 16'h7E81;
        sign_ext  = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid1 !== 1'b1 ||
            obs1 !== model_dec({1'b1, 16'h7E81}, ILL1, WB1)) begin
            n_err++;
            $display("FAIL post_reset: got v=%b %h want 1 %h", out_valid1,
                     obs1, model_dec({1'b1, 16'h7E81}, ILL1, WB1));
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        logic [31:0] e1, e2;
        for (int i = 0; i < 400; i++) begin
            w = 16'($urandom);
            if ($urandom_range(3) == 0) w[15:12] = 4'hF;
            instr     = w;
            sign_ext  = 1'($urandom);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(31) == 0);
            tick();
            n_vec++;
            if (in_ready1 !== m_ready || in_ready2 !== m_ready ||
                out_valid1 !== (mq.size() > 0) ||
                out_valid2 !== (mq.size() > 0)) begin
                n_err++;
                $display("FAIL rnd_hs%0d: got r=%b%b v=%b%b want r=%b v=%b",
                         i, in_ready1, in_ready2, out_valid1, out_valid2,
                         m_ready, (mq.size() > 0));
            end
            if (mq.size() > 0) begin
                e1 = model_dec(mq[0], ILL1, WB1);
                e2 = model_dec(mq[0], ILL2, WB2);
                n_vec++;
                if (obs1 !== e1 || obs2 !== e2) begin
                    n_err++;
                    $display("FAIL rnd_data%0d: got %h %h want %h %h",
                             i, obs1, obs2, e1, e2);
                end
            end
            n_vec++;
            if (cnt_o1 !== cnt1 || cnt_o2 !== cnt2) begin
                n_err++;
                $display("FAIL rnd_cnt%0d: got %0d %0d want %0d %0d",
                         i, cnt_o1, cnt_o2, cnt1, cnt2);
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode_fields();
        test_back_pressure();
        test_illegal();
        test_saturate();
        test_flush();
        test_reset_full();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
